l2_mem_resp: RTL and testbench

Line-granular memory responder that terminates the L2 cache's memory port (mem_addr / mem_rw / mem_wd / mem_rd / mem_complete). It accepts one 512-bit line read or write per request, waits a programmable access latency, and moves the line to or from a 128-bit-wide backing bank in four beats. It serves as the memory-side model for L2 bring-up and as the template for the eventual DRAM bridge.

---
 rtl/l2_mem_resp_pkg.sv | 16 +
 rtl/l2_mem_resp_mem_bank.sv | 26 ++
 rtl/l2_mem_resp.sv | 124 ++++++++++++
 tb/tb_l2_mem_resp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_resp_pkg.sv
// Shared constants for the L2 line responder: line/beat geometry and FSM state codes.
package l2_mem_resp_pkg;

  localparam int unsigned BEATS      = 4;
  localparam int unsigned BEAT_W     = 128;
  localparam int unsigned LINE_W     = 512;
  localparam int unsigned MEM_ADDR_W = 26;
  localparam int unsigned LAT_W      = 8;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWait  = 3'd1;
  localparam logic [2:0] StBurst = 3'd2;
  localparam logic [2:0] StFlush = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/l2_mem_resp_mem_bank.sv
// Single-port 128-bit backing bank with one-cycle synchronous read and write enable.
module l2_mem_resp_mem_bank
  import l2_mem_resp_pkg::*;
#(
  parameter int unsigned AddrW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AddrW-1:0]  addr,
  input  logic [BEAT_W-1:0] wdata,
  output logic [BEAT_W-1:0] rdata
);

  localparam int unsigned Words = 1 << AddrW;

  logic [BEAT_W-1:0] mem [Words];

  // Contents are deliberately left uninitialised and unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/l2_mem_resp.sv
// Line-granular memory responder: accepts one 512-bit read/write, waits LATENCY cycles,
// then moves the line to/from the 128-bit bank in four beats.
module l2_mem_resp
  import l2_mem_resp_pkg::*;
#(
  parameter int unsigned LINES   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_rw,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wd,
  output logic [LINE_W-1:0]     mem_rd,
  output logic                  mem_complete,
  output logic                  mem_busy
);

  localparam int unsigned     IdxW    = $clog2(LINES);
  localparam logic [LAT_W-1:0] LatLast = LAT_W'(LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic              rw_q, rw_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0] wd_q, wd_d;
  logic [LINE_W-1:0] rd_buf_q, rd_buf_d;

  logic              bank_we;
  logic [IdxW+1:0]   bank_addr;
  logic [BEAT_W-1:0] bank_wdata;
  logic [BEAT_W-1:0] bank_rdata;
  logic              capture;
  logic [1:0]        cap_beat;

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    rw_d      = rw_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    case (state_q)
      StIdle: begin
        if (mem_req) begin
          state_d   = StWait;
          rw_d      = mem_rw;
          idx_d     = mem_addr[IdxW-1:0];
          wd_d      = mem_wd;
          lat_cnt_d = '0;
          beat_d    = '0;
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q + 8'd1;
        if (lat_cnt_q == LatLast) begin
          state_d = StBurst;
        end
      end
      StBurst: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bank_we    = (state_q == StBurst) && rw_q;
  assign bank_addr  = {idx_q, beat_q};
  assign bank_wdata = wd_q[beat_q*BEAT_W +: BEAT_W];

  // Read data lags the issued beat by one cycle; FLUSH exists only to catch beat 3.
  assign capture  = !rw_q && (((state_q == StBurst) && (beat_q != 2'd0)) ||
                              (state_q == StFlush));
  assign cap_beat = beat_q - 2'd1;

  always_comb begin
    rd_buf_d = rd_buf_q;
    if (capture) begin
      rd_buf_d[cap_beat*BEAT_W +: BEAT_W] = bank_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      rw_q      <= 1'b0;
      idx_q     <= '0;
      wd_q      <= '0;
      rd_buf_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      rw_q      <= rw_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      rd_buf_q  <= rd_buf_d;
    end
  end

  l2_mem_resp_mem_bank #(
    .AddrW(IdxW + 2)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .addr (bank_addr),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

  assign mem_rd       = rd_buf_q;
  assign mem_complete = (state_q == StDone);
  assign mem_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_l2_mem_resp.sv
// Bench for l2_mem_resp: transaction-level timing/data model plus directed and random traffic.
module tb_l2_mem_resp;

  localparam int L     = 4;
  localparam int LINES = 1024;

  localparam logic [511:0] Wd0 = {128'h3f3e3d3c_3b3a3938_37363534_33323130,
                                  128'h2f2e2d2c_2b2a2928_27262524_23222120,
                                  128'h1f1e1d1c_1b1a1918_17161514_13121110,
                                  128'h0f0e0d0c_0b0a0908_07060504_03020100};
  localparam logic [511:0] Wd1 = {128'hdddddddd_00000003_dddddddd_00000003,
                                  128'hcccccccc_00000002_cccccccc_00000002,
                                  128'hbbbbbbbb_00000001_bbbbbbbb_00000001,
                                  128'haaaaaaaa_00000000_aaaaaaaa_00000000};
  localparam logic [511:0] OldL = {4{128'h0123456789abcdef_fedcba9876543210}};
  localparam logic [511:0] NewL = {4{128'h5555aaaa5555aaaa_5555aaaa5555aaaa}};

  logic         clk;
  logic         rst;
  logic         mem_req;
  logic         mem_rw;
  logic [25:0]  mem_addr;
  logic [511:0] mem_wd;
  logic [511:0] mem_rd;
  logic         mem_complete;
  logic         mem_busy;

  int n_checks = 0;
  int n_fail   = 0;

  l2_mem_resp #(
    .LINES  (LINES),
    .LATENCY(L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd),
    .mem_complete(mem_complete),
    .mem_busy    (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: a request accepted in cycle a is busy in a+1..a+L+6,
  // completes in a+L+6, writes beat k at the end of cycle a+L+1+k.
  int           cyc = 0;
  bit           chk_en = 0;
  bit           have_req = 0;
  int           a_c = 0;
  logic         m_rw = 1'b0;
  int           m_idx = 0;
  logic [511:0] m_wd = '0;
  logic [511:0] exp_rd = '0;
  logic [3:0]   exp_mask = 4'hf;
  logic [511:0] mline [int];
  logic [3:0]   mknown [int];

  initial begin : model
    int k;
    logic [511:0] t;
    forever begin
      @(posedge clk);
      if (!rst) begin
        // The beat issued in the reset cycle may or may not land; treat it as unknown.
        if (have_req && m_rw && cyc >= a_c + L + 1 && cyc <= a_c + L + 4) begin
          k = cyc - (a_c + L + 1);
          mknown[m_idx][k] = 1'b0;
        end
        have_req = 0;
        exp_rd   = '0;
        exp_mask = 4'hf;
        chk_en   = 1;
      end else begin
        if (have_req && cyc > a_c + L + 6) have_req = 0;
        if (have_req) begin
          if (m_rw && cyc >= a_c + L + 1 && cyc <= a_c + L + 4) begin
            k = cyc - (a_c + L + 1);
            t = mline[m_idx];
            t[k*128 +: 128] = m_wd[k*128 +: 128];
            mline[m_idx] = t;
            mknown[m_idx][k] = 1'b1;
          end
          if (!m_rw && cyc == a_c + L + 5) begin
            exp_rd   = mline[m_idx];
            exp_mask = mknown[m_idx];
          end
        end else if (mem_req) begin
          have_req = 1;
          a_c      = cyc;
          m_rw     = mem_rw;
          m_idx    = int'(mem_addr[9:0]);
          m_wd     = mem_wd;
          if (!mline.exists(m_idx)) begin
            mline[m_idx]  = '0;
            mknown[m_idx] = 4'h0;
          end
        end
      end
      cyc++;
    end
  end

  initial begin : compare
    logic [511:0] m;
    bit in_req;
    bit settling;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        in_req   = have_req && cyc >= a_c + 1 && cyc <= a_c + L + 6;
        settling = have_req && !m_rw && cyc >= a_c + L + 2 && cyc <= a_c + L + 5;
        check("mem_busy", 512'(mem_busy), 512'(in_req));
        check("mem_complete", 512'(mem_complete), 512'(have_req && cyc == a_c + L + 6));
        if (!settling) begin
          for (int b = 0; b < 4; b++) m[b*128 +: 128] = {128{exp_mask[b]}};
          check("mem_rd", mem_rd & m, exp_rd & m);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request from the current cycle, waits for completion, drops mem_req after it.
  task automatic issue(input logic rw, input logic [25:0] addr, input logic [511:0] wd,
                       input bit toggle, output int start_c, output int done_c,
                       output logic [511:0] rd);
    mem_req  = 1'b1;
    mem_rw   = rw;
    mem_addr = addr;
    mem_wd   = wd;
    start_c  = cyc;
    done_c   = -1;
    rd       = '0;
    for (int i = 0; i < 60 && done_c < 0; i++) begin
      @(negedge clk);
      if (mem_complete === 1'b1) begin
        done_c = cyc;
        rd     = mem_rd;
      end else if (toggle && i > 0) begin
        mem_rw   = 1'($urandom());
        mem_addr = 26'($urandom());
        for (int w = 0; w < 16; w++) mem_wd[w*32 +: 32] = $urandom();
      end
    end
    if (done_c < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL completion_timeout: got none expected pulse within 60 cycles");
    end
    @(posedge clk);
    #1;
    mem_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500us");
    $fatal(1);
  end

  initial begin : stim
    int s1, d1, s2, d2, s3, d3;
    logic [511:0] rd;
    logic [25:0] addr;
    logic [511:0] wd;
    int pool [8] = '{3, 7, 100, 511, 512, 777, 1000, 1023};

    rst      = 1'b0;
    mem_req  = 1'b1;
    mem_rw   = 1'b1;
    mem_addr = 26'h10;
    mem_wd   = Wd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 512'(mem_busy), 512'(0));
    check("reset_complete", 512'(mem_complete), 512'(0));
    check("reset_rd", mem_rd, 512'(0));
    @(posedge clk);
    #1;
    rst     = 1'b1;
    mem_req = 1'b0;
    idle(2);

    issue(1'b1, 26'h0000010, Wd0, 1'b0, s1, d1, rd);
    check("write_latency", 512'(d1 - s1), 512'(10));
    issue(1'b0, 26'h0000010, '0, 1'b0, s1, d1, rd);
    check("read_latency", 512'(d1 - s1), 512'(10));
    check("read_data", rd, Wd0);
    check("read_beat0", 512'(rd[127:0]), 512'(128'h0f0e0d0c_0b0a0908_07060504_03020100));

    idle(1);
    issue(1'b1, 26'h0000400, Wd1, 1'b0, s1, d1, rd);
    issue(1'b0, 26'h0000000, '0, 1'b0, s1, d1, rd);
    check("wrap_read", rd, Wd1);

    // Back-to-back, with inputs scrambled after acceptance on the middle write.
    idle(2);
    issue(1'b0, 26'h0000010, '0, 1'b1, s1, d1, rd);
    check("b2b_first_rd", rd, Wd0);
    issue(1'b1, 26'h0000020, Wd1, 1'b1, s2, d2, rd);
    issue(1'b0, 26'h0000020, '0, 1'b0, s3, d3, rd);
    check("b2b_accept_gap", 512'(s2 - s1), 512'(11));
    check("b2b_accept_gap2", 512'(s3 - s2), 512'(11));
    check("latched_write", rd, Wd1);

    // Reset on the second BURST cycle of a write to idx 5.
    idle(1);
    issue(1'b1, 26'h0000005, OldL, 1'b0, s1, d1, rd);
    idle(1);
    mem_req  = 1'b1;
    mem_rw   = 1'b1;
    mem_addr = 26'h0000005;
    mem_wd   = NewL;
    repeat (L + 2) @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 512'(mem_busy), 512'(0));
    idle(1);
    issue(1'b0, 26'h0000005, '0, 1'b0, s1, d1, rd);
    check("abort_beat0_new", 512'(rd[127:0]), 512'(NewL[127:0]));
    check("abort_beat23_old", 512'(rd[511:256]), 512'(OldL[511:256]));

    for (int n = 0; n < 48; n++) begin
      addr = (26'($urandom_range(0, 65535)) << 10) | 26'(pool[$urandom_range(0, 7)]);
      for (int w = 0; w < 16; w++) wd[w*32 +: 32] = $urandom();
      issue(1'($urandom()), addr, wd, 1'($urandom()), s1, d1, rd);
      check("rand_latency", 512'(d1 - s1), 512'(10));
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
